// File: rtl/csa_resolve_seq.sv
// csa_resolve_seq: sequential carry-propagate resolver for carry-save pairs.
// Adds s0+s1 CHUNK bits per cycle through one small adder and a carry flop,
// so the full-width carry chain is never built. Valid/ready on both sides.
module csa_resolve_seq #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned CHUNK = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE:0]   s0,
  input  logic [SIZE:0]   s1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE+1:0] sum,
  output logic            busy
);

  localparam int unsigned NS = (SIZE + 1 + CHUNK - 1) / CHUNK;
  localparam int unsigned W  = NS * CHUNK;
  localparam int unsigned IW = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned SW = SIZE + 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   add;

  // Select the operand slices addressed by the current slice index.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (idx_q == IW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // Single CHUNK+1-bit adder shared by every slice.
  always_comb begin
    add = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
  end

  // Next-state and datapath update for IDLE -> RUN -> DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = W'(s0);
          b_d     = W'(s1);
          carry_d = 1'b0;
          idx_d   = '0;
          res_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int unsigned i = 0; i < NS; i++) begin
          if (idx_q == IW'(i)) begin
            res_d[i*CHUNK +: CHUNK] = add[CHUNK-1:0];
          end
        end
        carry_d = add[CHUNK];
        if (idx_q == IW'(NS - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Status decodes of the state register; the sum drops only zero padding.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = SW'({carry_q, res_q});

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Scoreboard bench for csa_resolve_seq: four instances (CHUNK 3, 1, 4, 9),
// a driver that queues expectations and a monitor that checks them.
module tb_csa_resolve_seq;

  localparam int NI = 4;

  typedef struct {
    int         inst;
    logic [9:0] sm;
    int         acc;
  } exp_t;

  typedef struct {
    int         cyc;
    int         inst;
    logic       ir;
    logic       bz;
    logic       ov;
    logic [9:0] sm;
    int         tag;
  } st_t;

  logic       clk;
  logic       rst;
  logic       in_valid  [NI];
  logic       in_ready  [NI];
  logic [8:0] s0        [NI];
  logic [8:0] s1        [NI];
  logic       out_valid [NI];
  logic       out_ready [NI];
  logic [9:0] sum       [NI];
  logic       busy      [NI];

  int   cyc = 0;
  bit   fin = 1'b0;
  exp_t eq[$];
  st_t  sq[$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned CHK = (g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 4 : 9;
    csa_resolve_seq #(.SIZE(8), .CHUNK(CHK)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .s0        (s0[g]),
      .s1        (s1[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .sum       (sum[g]),
      .busy      (busy[g])
    );
  end

  // Free-running clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ns_of(input int i);
    case (i)
      0:       return 3;
      1:       return 9;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_status(input int i, input int at, input logic ir, input logic bz,
                               input logic ov, input logic [9:0] sm, input int tag);
    st_t s;
    s.cyc = at; s.inst = i; s.ir = ir; s.bz = bz; s.ov = ov; s.sm = sm; s.tag = tag;
    sq.push_back(s);
  endtask

  // Wait for in_ready, present one pair for one cycle, queue its expected sum.
  task automatic send(input int i, input logic [8:0] a, input logic [8:0] b,
                      input logic [9:0] e, input bit track);
    int   n;
    exp_t x;
    n = 0;
    while (in_ready[i] !== 1'b1) begin
      tick();
      n++;
      if (n > 100) begin
        $display("FAIL in_ready_timeout inst=%0d waited=%0d cycles, required in_ready=1", i, n);
        $fatal(1, "in_ready never rose");
      end
    end
    s0[i] = a;
    s1[i] = b;
    in_valid[i] = 1'b1;
    tick();
    in_valid[i] = 1'b0;
    if (track) begin
      x.inst = i; x.sm = e; x.acc = cyc;
      eq.push_back(x);
    end
  endtask

  // Driver: directed vectors with hand-computed sums, then a CHUNK sweep.
  initial begin
    logic [8:0] dv_a [6];
    logic [8:0] dv_b [6];
    logic [9:0] dv_e [6];
    logic [8:0] ra, rb;
    int a, n;

    dv_a[0] = 9'h1FF; dv_b[0] = 9'h001; dv_e[0] = 10'h200;
    dv_a[1] = 9'h1FF; dv_b[1] = 9'h1FF; dv_e[1] = 10'h3FE;
    dv_a[2] = 9'h0AA; dv_b[2] = 9'h055; dv_e[2] = 10'h0FF;
    dv_a[3] = 9'h000; dv_b[3] = 9'h000; dv_e[3] = 10'h000;
    dv_a[4] = 9'h100; dv_b[4] = 9'h100; dv_e[4] = 10'h200;
    dv_a[5] = 9'h155; dv_b[5] = 9'h0AB; dv_e[5] = 10'h200;

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b1; s0[i] = '0; s1[i] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < NI; i++) expect_status(i, cyc, 1'b1, 1'b0, 1'b0, 10'h000, 1);
    tick();

    // Basic latency and return to IDLE.
    send(0, 9'h005, 9'h003, 10'h008, 1'b1);
    a = cyc;
    expect_status(0, a,     1'b0, 1'b1, 1'b0, 10'h000, 2);
    expect_status(0, a + 3, 1'b0, 1'b1, 1'b1, 10'h008, 3);
    expect_status(0, a + 4, 1'b1, 1'b0, 1'b0, 10'h008, 4);
    repeat (6) tick();

    // Full-length carry and the all-ones compressor pair.
    send(0, 9'h1FF, 9'h001, 10'h200, 1'b1);
    send(0, 9'h1FF, 9'h1FF, 10'h3FE, 1'b1);
    repeat (6) tick();

    // Backpressure: hold the result, ignore a second input meanwhile.
    out_ready[0] = 1'b0;
    send(0, 9'h123, 9'h0DD, 10'h200, 1'b1);
    a = cyc;
    repeat (3) tick();
    for (int k = 0; k < 5; k++) begin
      expect_status(0, cyc, 1'b0, 1'b1, 1'b1, 10'h200, 10 + k);
      if (k == 1) begin
        s0[0] = 9'h1FF; s1[0] = 9'h1FF; in_valid[0] = 1'b1;
      end
      if (k == 2) in_valid[0] = 1'b0;
      tick();
    end
    out_ready[0] = 1'b1;
    expect_status(0, cyc + 1, 1'b1, 1'b0, 1'b0, 10'h200, 20);
    tick();
    tick();
    send(0, 9'h0AA, 9'h055, 10'h0FF, 1'b1);
    repeat (6) tick();

    // Reset one cycle after acceptance: job is discarded, nothing emitted.
    send(0, 9'h1FF, 9'h1FF, 10'h3FE, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_status(0, cyc, 1'b1, 1'b0, 1'b0, 10'h000, 30);
    repeat (8) tick();

    // CHUNK sweep: directed table plus random pairs against a reference add.
    for (int i = 1; i < NI; i++) begin
      for (int v = 0; v < 6; v++) send(i, dv_a[v], dv_b[v], dv_e[v], 1'b1);
      for (int v = 0; v < 4; v++) begin
        ra = 9'($urandom_range(0, 511));
        rb = 9'($urandom_range(0, 511));
        send(i, ra, rb, 10'({1'b0, ra}) + 10'({1'b0, rb}), 1'b1);
      end
    end

    n = 0;
    while (eq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    fin = 1'b1;
  end

  // Monitor: compares outputs and queued status expectations at negedge.
  initial begin
    int   n_pass;
    int   n_total;
    bit   shown [NI];
    int   j;
    st_t  s;
    n_pass = 0;
    n_total = 0;
    for (int i = 0; i < NI; i++) shown[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (out_valid[i] === 1'b1) begin
          j = -1;
          for (int k = 0; k < eq.size(); k++) begin
            if (j < 0 && eq[k].inst == i) j = k;
          end
          if (j < 0) begin
            n_total++;
            $display("FAIL unexpected_output inst=%0d cyc=%0d got sum=%h, required no output", i, cyc, sum[i]);
          end else begin
            if (!shown[i]) begin
              n_total++;
              if (cyc - eq[j].acc == ns_of(i)) n_pass++;
              else $display("FAIL latency inst=%0d got %0d cycles, required %0d", i, cyc - eq[j].acc, ns_of(i));
              shown[i] = 1'b1;
            end
            n_total++;
            if (sum[i] === eq[j].sm) n_pass++;
            else $display("FAIL sum inst=%0d cyc=%0d got %h, required %h", i, cyc, sum[i], eq[j].sm);
            if (out_ready[i] === 1'b1) begin
              eq.delete(j);
              shown[i] = 1'b0;
            end
          end
        end
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        s = sq.pop_front();
        n_total++;
        if ({in_ready[s.inst], busy[s.inst], out_valid[s.inst], sum[s.inst]} ===
            {s.ir, s.bz, s.ov, s.sm}) begin
          n_pass++;
        end else begin
          $display("FAIL status tag=%0d inst=%0d cyc=%0d got ir/busy/ov/sum=%b/%b/%b/%h required %b/%b/%b/%h",
                   s.tag, s.inst, cyc, in_ready[s.inst], busy[s.inst], out_valid[s.inst],
                   sum[s.inst], s.ir, s.bz, s.ov, s.sm);
        end
      end
      if (fin) begin
        n_total++;
        if (eq.size() == 0) n_pass++;
        else $display("FAIL pending_outputs got %0d outstanding, required 0", eq.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
      end
    end
  end

  // Absolute bound on run time.
  initial begin
    #300000;
    $display("FAIL watchdog expired at cyc=%0d, required run to complete", cyc);
    $fatal(1, "watchdog");
  end

endmodule
